seven_seg_capture: RTL and testbench

Receive-side counterpart of the segment encoder. It samples a time-multiplexed 7-segment display bus (one-hot digit select plus an 8-bit segment/decimal-point bus) and reconstructs the 8 hex digits and decimal points. It is used as a self-check and loopback monitor between the display driver and the FPGA pins, or as a capture front-end for an external display.

---
 rtl/seven_seg_capture.sv | 153 +++++++++++++++
 tb/tb_seven_seg_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - multiplexed 7-segment bus capture; `define ACTIVE_LOW_SEG_EN for active-low pins
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       en,
    input  logic [NUM_DIGITS-1:0]      scan_sel,
    input  logic [7:0]                 seg_in,
    output logic [NUM_DIGITS-1:0][3:0] digits,
    output logic [NUM_DIGITS-1:0]      flt_pt,
    output logic [NUM_DIGITS-1:0]      digit_ok,
    output logic                       frame_done,
    output logic                       sel_err
);

    localparam int         SW     = NUM_DIGITS + 8;
    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    // Returns {legal, value}; anything that is not one of the 16 hex glyphs decodes to 0, illegal.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Pin polarity normalised so everything downstream sees active-high select and segments.
    logic [SW-1:0] pin_s;
`ifdef ACTIVE_LOW_SEG_EN
    assign pin_s = ~{scan_sel, seg_in};
`else
    assign pin_s = {scan_sel, seg_in};
`endif

    logic [SW-1:0]                 samp_q, samp_d;
    logic [7:0]                    cnt_q, cnt_d;
    logic                          cap_q, cap_d;
    logic [NUM_DIGITS-1:0][3:0]    digits_q, digits_d;
    logic [NUM_DIGITS-1:0]         flt_pt_q, flt_pt_d;
    logic [NUM_DIGITS-1:0]         digit_ok_q, digit_ok_d;
    logic [NUM_DIGITS-1:0]         seen_q, seen_d;
    logic                          frame_done_q, frame_done_d;
    logic                          sel_err_q, sel_err_d;

    logic                          same;
    logic [NUM_DIGITS-1:0]         cap_sel;
    logic [7:0]                    cap_seg;
    logic [4:0]                    glyph;
    logic [NUM_DIGITS-1:0]         seen_nxt;

    // Stability tracking: count identical consecutive samples, fire one capture per dwell.
    always_comb begin
        same   = (pin_s == samp_q);
        samp_d = pin_s;
        cnt_d  = cnt_q;
        cap_d  = 1'b0;
        if (!en) begin
            cnt_d = 8'd0;
        end else begin
            if (!same) begin
                cnt_d = 8'd1;
            end else if (cnt_q < SETTLE) begin
                cnt_d = cnt_q + 8'd1;
            end
            // A mismatch re-arms the capture even when SETTLE is 1 and the counter stays at 1.
            cap_d = (cnt_d == SETTLE) && (!same || (cnt_q != SETTLE));
        end
    end

    // Capture handling one edge after the capture event; samp_q still holds the captured sample.
    always_comb begin
        cap_sel      = samp_q[SW-1:8];
        cap_seg      = samp_q[7:0];
        glyph        = decode_glyph(cap_seg[6:0]);
        digits_d     = digits_q;
        flt_pt_d     = flt_pt_q;
        digit_ok_d   = digit_ok_q;
        seen_d       = seen_q;
        seen_nxt     = seen_q | cap_sel;
        frame_done_d = 1'b0;
        sel_err_d    = 1'b0;
        if (cap_q) begin
            if ($onehot(cap_sel)) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (cap_sel[i]) begin
                        digits_d[i]   = glyph[3:0];
                        flt_pt_d[i]   = cap_seg[7];
                        digit_ok_d[i] = glyph[4];
                    end
                end
                if (&seen_nxt) begin
                    frame_done_d = 1'b1;
                    seen_d       = '0;
                end else begin
                    seen_d = seen_nxt;
                end
            end else if (!$onehot0(cap_sel)) begin
                sel_err_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            samp_q       <= '0;
            cnt_q        <= '0;
            cap_q        <= 1'b0;
            digits_q     <= '0;
            flt_pt_q     <= '0;
            digit_ok_q   <= '0;
            seen_q       <= '0;
            frame_done_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            samp_q       <= samp_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            digits_q     <= digits_d;
            flt_pt_q     <= flt_pt_d;
            digit_ok_q   <= digit_ok_d;
            seen_q       <= seen_d;
            frame_done_q <= frame_done_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign digits     = digits_q;
    assign flt_pt     = flt_pt_q;
    assign digit_ok   = digit_ok_q;
    assign frame_done = frame_done_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed and random stimulus for seven_seg_capture against a behavioural model
module tb_seven_seg_capture;

    localparam int S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            nrst, en;
    logic [7:0]      sel_l, seg_l;
    logic [7:0]      scan_sel, seg_in;
    logic [7:0][3:0] digits;
    logic [7:0]      flt_pt, digit_ok;
    logic            frame_done, sel_err;

`ifdef ACTIVE_LOW_SEG_EN
    assign scan_sel = ~sel_l;
    assign seg_in   = ~seg_l;
`else
    assign scan_sel = sel_l;
    assign seg_in   = seg_l;
`endif

    seven_seg_capture #(.NUM_DIGITS(8), .SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .scan_sel   (scan_sel),
        .seg_in     (seg_in),
        .digits     (digits),
        .flt_pt     (flt_pt),
        .digit_ok   (digit_ok),
        .frame_done (frame_done),
        .sel_err    (sel_err)
    );

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    logic [3:0]  m_dig [8];
    logic [7:0]  m_dp, m_ok, m_seen;
    logic        m_fd, m_se;
    int          m_run;
    logic [15:0] m_prev, m_pend_s;
    bit          m_pend;

    int total = 0;
    int bad = 0;
    int fd_count = 0;
    int se_count = 0;

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int v = 0; v < 16; v++) begin
            if (glyph[v] == p) return {1'b1, 4'(v)};
        end
        return 5'b0;
    endfunction

    task automatic model_apply(input logic [15:0] s);
        logic [7:0] sel;
        logic [4:0] dec;
        sel = s[15:8];
        dec = ref_decode(s[6:0]);
        if (sel == 8'h00) return;
        if ($countones(sel) > 1) begin
            m_se = 1'b1;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) begin
                m_dig[i]  = dec[3:0];
                m_dp[i]   = s[7];
                m_ok[i]   = dec[4];
                m_seen[i] = 1'b1;
            end
        end
        if (m_seen == 8'hFF) begin
            m_fd   = 1'b1;
            m_seen = 8'h00;
        end
    endtask

    task automatic model_edge(input logic [15:0] s);
        m_fd = 1'b0;
        m_se = 1'b0;
        if (!nrst) begin
            for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
            m_dp = 0; m_ok = 0; m_seen = 0;
            m_run = 0; m_prev = 0; m_pend = 0; m_pend_s = 0;
            return;
        end
        if (m_pend) model_apply(m_pend_s);
        m_pend = 0;
        if (!en) m_run = 0;
        else if (s != m_prev) m_run = 1;
        else m_run = m_run + 1;
        m_prev = s;
        if (en && m_run == S) begin
            m_pend   = 1;
            m_pend_s = s;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] ed;
        for (int i = 0; i < 8; i++) ed[i*4 +: 4] = m_dig[i];
        check("digits", digits, ed);
        check("flt_pt", flt_pt, m_dp);
        check("digit_ok", digit_ok, m_ok);
        check("frame_done", frame_done, m_fd);
        check("sel_err", sel_err, m_se);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge({sel_l, seg_l});
        #1;
        check_all();
        if (frame_done === 1'b1) fd_count++;
        if (sel_err === 1'b1) se_count++;
    endtask

    task automatic hold(input logic [7:0] sel, input logic [7:0] seg, input int n);
        sel_l = sel;
        seg_l = seg;
        repeat (n) cycle();
    endtask

    task automatic do_reset(input int n);
        nrst = 1'b0;
        repeat (n) cycle();
        nrst = 1'b1;
    endtask

    task automatic capture(input int d, input int v);
        hold(8'(1 << d), {1'b0, glyph[v]}, 6);
        hold(8'h00, 8'h00, 2);
    endtask

    initial begin
        // Reset then static inputs: latency of SETTLE+1 edges
        en = 1'b1; nrst = 1'b0; sel_l = 8'h01; seg_l = 8'hBF;
        repeat (2) cycle();
        check("rst_digits", digits, 0);
        check("rst_ok", digit_ok, 0);
        check("rst_dp", flt_pt, 0);
        check("rst_fd", frame_done, 0);
        check("rst_se", sel_err, 0);
        nrst = 1'b1; fd_count = 0;
        repeat (4) cycle();
        check("lat_early_ok0", digit_ok[0], 0);
        cycle();
        check("lat_ok0", digit_ok[0], 1);
        check("lat_dig0", digits[0], 0);
        check("lat_dp0", flt_pt[0], 1);
        hold(8'h01, 8'hBF, 4);
        check("lat_no_fd", fd_count, 0);

        // Full frame 0..7 with values 1..8
        do_reset(2); fd_count = 0; se_count = 0;
        for (int d = 0; d < 8; d++) capture(d, d + 1);
        check("frame_digits", digits, 32'h87654321);
        check("frame_ok", digit_ok, 8'hFF);
        check("frame_fd_count", fd_count, 1);
        check("frame_se_count", se_count, 0);

        // Glitch rejection on digit 2
        do_reset(2);
        repeat (4) begin
            hold(8'h04, 8'h06, 2);
            hold(8'h04, 8'h5B, 2);
        end
        check("glitch_dig2", digits[2], 0);
        check("glitch_ok2", digit_ok[2], 0);
        hold(8'h04, 8'h4F, 6);
        check("glitch_final_dig2", digits[2], 3);
        check("glitch_final_ok2", digit_ok[2], 1);

        // Illegal glyph on digit 4 still marks it seen
        fd_count = 0;
        hold(8'h10, 8'h55, 6);
        hold(8'h00, 8'h00, 2);
        check("illegal_dig4", digits[4], 0);
        check("illegal_ok4", digit_ok[4], 0);
        capture(0, 10); capture(1, 11); capture(3, 12);
        capture(5, 13); capture(6, 14);
        check("illegal_pre_fd", fd_count, 0);
        capture(7, 15);
        check("illegal_seen_fd", fd_count, 1);

        // Multi-hot select
        do_reset(2);
        capture(0, 9); capture(1, 10);
        se_count = 0;
        hold(8'h03, {1'b0, glyph[5]}, 10);
        hold(8'h00, 8'h00, 2);
        check("multi_se_count", se_count, 1);
        check("multi_dig0", digits[0], 9);
        check("multi_dig1", digits[1], 10);

        // Enable pause between digits 6 and 7
        do_reset(2); fd_count = 0;
        for (int d = 0; d < 7; d++) capture(d, d);
        en = 1'b0;
        hold(8'h80, {1'b0, glyph[12]}, 5);
        check("en_off_ok7", digit_ok[7], 0);
        en = 1'b1;
        hold(8'h80, {1'b0, glyph[12]}, 6);
        check("en_fd_count", fd_count, 1);
        check("en_dig7", digits[7], 12);

        // Reset between digits 6 and 7
        do_reset(2); fd_count = 0;
        for (int d = 0; d < 7; d++) capture(d, d);
        do_reset(2);
        check("mid_rst_digits", digits, 0);
        check("mid_rst_ok", digit_ok, 0);
        check("mid_rst_dp", flt_pt, 0);
        fd_count = 0;
        capture(7, 15);
        check("mid_rst_fd", fd_count, 0);
        check("mid_rst_ok7", digit_ok, 8'h80);

        // Random traffic against the model
        for (int it = 0; it < 400; it++) begin
            int r;
            logic [7:0] s;
            logic [7:0] g;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset(1);
            end else begin
                en = ($urandom_range(0, 9) != 0);
                r = $urandom_range(0, 99);
                if (r < 60)      s = 8'(1 << $urandom_range(0, 7));
                else if (r < 75) s = 8'h00;
                else if (r < 90) s = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
                else             s = 8'($urandom);
                if ($urandom_range(0, 9) < 7) g = {1'($urandom), glyph[$urandom_range(0, 15)]};
                else                          g = 8'($urandom);
                hold(s, g, $urandom_range(1, 7));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
